// File: rtl/pwm_dac.sv
// Audio PWM DAC: a small sample FIFO feeds one duty code per 2^CODE_WIDTH-cycle frame.
// Define PWM_DAC_MIDSCALE_IDLE_EN to idle at mid-scale, not the last code, on underrun and at reset.
module pwm_dac #(
  parameter int CODE_WIDTH = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [CODE_WIDTH-1:0]         din,
  input  logic                          din_valid,
  output logic                          din_ready,
  output logic                          pwm_out,
  output logic                          frame_start,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          underrun,
  input  logic                          underrun_clr
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CODE_WIDTH-1:0] CODE_MAX   = '1;
  localparam logic [CNT_W-1:0]      COUNT_FULL = CNT_W'(FIFO_DEPTH);
`ifdef PWM_DAC_MIDSCALE_IDLE_EN
  localparam logic [CODE_WIDTH-1:0] MID_CODE   = {1'b1, {(CODE_WIDTH-1){1'b0}}};
  localparam logic [CODE_WIDTH-1:0] DUTY_RESET = MID_CODE;
`else
  localparam logic [CODE_WIDTH-1:0] DUTY_RESET = '0;
`endif

  logic [CODE_WIDTH-1:0] cnt;
  logic [CODE_WIDTH-1:0] cnt_next;
  logic [CODE_WIDTH-1:0] duty;
  logic [CODE_WIDTH-1:0] duty_next;
  logic [CODE_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  boundary;
  logic                  fifo_empty;
  logic                  push;
  logic                  pop;

  assign din_ready = (fifo_count != COUNT_FULL);

  // The pop looks only at the registered count, so a push landing on the
  // boundary cycle is not visible to it and the frame counts as an underrun.
  always_comb begin
    cnt_next   = cnt + 1'b1;
    boundary   = (cnt == CODE_MAX);
    fifo_empty = (fifo_count == '0);
    push       = din_valid && din_ready;
    pop        = boundary && !fifo_empty;
    duty_next  = duty;
    if (boundary) begin
      if (!fifo_empty) begin
        duty_next = mem[rd_ptr];
      end
`ifdef PWM_DAC_MIDSCALE_IDLE_EN
      else begin
        duty_next = MID_CODE;
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      duty        <= DUTY_RESET;
      pwm_out     <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      cnt         <= cnt_next;
      duty        <= duty_next;
      pwm_out     <= (cnt_next < duty_next);
      frame_start <= (cnt_next == '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      underrun <= 1'b0;
    end else if (boundary && fifo_empty) begin
      underrun <= 1'b1;
    end else if (underrun_clr) begin
      underrun <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Storage needs no reset; the pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= din;
    end
  end

endmodule

// File: tb/tb_pwm_dac.sv
// Randomized bench for pwm_dac against a frame-level model (queue of codes, phase within frame).
module tb_pwm_dac;

  localparam int CW    = 10;
  localparam int DEPTH = 4;
  localparam int FRAME = 1 << CW;
`ifdef PWM_DAC_MIDSCALE_IDLE_EN
  localparam int IDLE_DUTY = FRAME / 2;
`else
  localparam int IDLE_DUTY = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CW-1:0] din = '0;
  logic          din_valid = 1'b0;
  logic          din_ready;
  logic          pwm_out;
  logic          frame_start;
  logic [2:0]    fifo_count;
  logic          underrun;
  logic          underrun_clr = 1'b0;

  pwm_dac #(.CODE_WIDTH(CW), .FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .din          (din),
    .din_valid    (din_valid),
    .din_ready    (din_ready),
    .pwm_out      (pwm_out),
    .frame_start  (frame_start),
    .fifo_count   (fifo_count),
    .underrun     (underrun),
    .underrun_clr (underrun_clr)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Model: phase within frame, duty in force, queued codes, sticky flag.
  int m_phase;
  int m_duty;
  int m_q[$];
  bit m_ur;
  bit m_wrapped;
  int m_hi;
  bit last_acc;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (phase %0d, t=%0t)", tag, obs, exp, m_phase, $time);
    end
  endtask

  task automatic model_reset();
    m_phase   = 0;
    m_duty    = IDLE_DUTY;
    m_q.delete();
    m_ur      = 0;
    m_wrapped = 0;
    m_hi      = 0;
  endtask

  task automatic check_outputs();
    if (m_phase == 0) m_hi = 0;
    chk("pwm_out", int'(pwm_out), int'(m_phase < m_duty));
    m_hi += int'(pwm_out);
    chk("frame_start", int'(frame_start), int'(m_phase == 0 && m_wrapped));
    chk("fifo_count", int'(fifo_count), m_q.size());
    chk("din_ready", int'(din_ready), int'(m_q.size() != DEPTH));
    chk("underrun", int'(underrun), int'(m_ur));
    if (m_phase == FRAME - 1 && m_wrapped) chk("high_time", m_hi, m_duty);
  endtask

  // Called at a negedge: apply inputs, advance model across the next posedge, then check.
  task automatic cyc(input logic v, input logic [CW-1:0] d, input logic c);
    bit bnd;
    bit empty;
    din_valid    = v;
    din          = d;
    underrun_clr = c;
    bnd      = (m_phase == FRAME - 1);
    empty    = (m_q.size() == 0);
    last_acc = v && (m_q.size() != DEPTH);
    if (bnd && !empty) m_duty = m_q.pop_front();
    if (bnd && empty) begin
      m_ur = 1;
      m_duty = (IDLE_DUTY != 0) ? IDLE_DUTY : m_duty;
    end else if (c) begin
      m_ur = 0;
    end
    if (last_acc) m_q.push_back(int'(d));
    m_phase = (m_phase + 1) % FRAME;
    if (m_phase == 0) m_wrapped = 1;
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, CW'($urandom), 1'b0);
  endtask

  task automatic run_to(input int p);
    while (m_phase != p) cyc(1'b0, CW'($urandom), 1'b0);
  endtask

  // Called at a negedge; reset asserts mid-low-phase so no clock edge interferes.
  task automatic do_reset();
    din_valid    = 1'b0;
    underrun_clr = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_pwm_out", int'(pwm_out), 0);
    chk("rst_fifo_count", int'(fifo_count), 0);
    chk("rst_din_ready", int'(din_ready), 1);
    chk("rst_underrun", int'(underrun), 0);
    chk("rst_frame_start", int'(frame_start), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int n;
    int p;
    int rate;
    logic v;
    model_reset();
    @(negedge clk);
    do_reset();

    // Idle: underrun after first boundary, pwm low, frame_start every frame.
    idle(FRAME + 5);
    chk("idle_underrun", int'(underrun), 1);

    // Single sample of 300.
    cyc(1'b0, '0, 1'b1);
    chk("clr_underrun", int'(underrun), 0);
    cyc(1'b1, CW'(300), 1'b0);
    run_to(FRAME - 1);
    cyc(1'b0, '0, 1'b0);
    chk("pop_300_count", int'(fifo_count), 0);
    run_to(FRAME - 1);

    // Fill the FIFO, then hold din_valid until the boundary pop frees a slot.
    run_to(10);
    cyc(1'b1, CW'(0), 1'b0);
    cyc(1'b1, CW'(1023), 1'b0);
    cyc(1'b1, CW'(1), 1'b0);
    cyc(1'b1, CW'(512), 1'b0);
    chk("full_count", int'(fifo_count), 4);
    chk("full_ready", int'(din_ready), 0);
    n = 0;
    p = -1;
    do begin
      p = m_phase;
      cyc(1'b1, CW'(77), 1'b0);
      n++;
    end while (!last_acc && n < 3000);
    chk("held_accepted", int'(last_acc), 1);
    chk("held_accept_phase", p, 0);
    idle(5 * FRAME);

    // Push on the boundary with the FIFO empty, then clear races.
    cyc(1'b0, '0, 1'b1);
    run_to(FRAME - 1);
    cyc(1'b1, CW'(600), 1'b0);
    chk("bnd_push_underrun", int'(underrun), 1);
    chk("bnd_push_count", int'(fifo_count), 1);
    run_to(5);
    cyc(1'b0, '0, 1'b1);
    chk("later_clr", int'(underrun), 0);
    run_to(FRAME - 1);
    cyc(1'b0, '0, 1'b0);
    run_to(FRAME - 1);
    cyc(1'b0, '0, 1'b1);
    chk("set_beats_clr", int'(underrun), 1);

    // Randomized frames with varying push rates and occasional clears.
    for (int f = 0; f < 6; f++) begin
      rate = $urandom_range(0, 3);
      for (int i = 0; i < FRAME; i++) begin
        case (rate)
          0:       v = 1'b0;
          1:       v = ($urandom_range(0, 799) == 0);
          2:       v = ($urandom_range(0, 199) == 0);
          default: v = 1'($urandom_range(0, 1));
        endcase
        cyc(v, CW'($urandom), 1'($urandom_range(0, 499) == 0));
      end
    end

    // Mid-frame reset with duty 700 and three entries queued.
    do_reset();
    cyc(1'b1, CW'(700), 1'b0);
    run_to(FRAME - 1);
    cyc(1'b0, '0, 1'b0);
    cyc(1'b1, CW'(101), 1'b0);
    cyc(1'b1, CW'(102), 1'b0);
    cyc(1'b1, CW'(103), 1'b0);
    run_to(100);
    chk("pre_rst_pwm", int'(pwm_out), 1);
    chk("pre_rst_count", int'(fifo_count), 3);
    do_reset();
    idle(2 * FRAME + 5);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
